decode_writeback: RTL and testbench
===================================

// Module: decode_writeback
// PURPOSE
//  SEQ decode + write-back stage: consumes icode/rA/rB from fetch, selects srcA/srcB/dstE/dstM,
//  reads valA/valB combinationally from a 15 x 64-bit register file, and commits valE/valM at the
//  clock edge closing the instruction. Also holds the sticky processor status (AOK/HLT/ADR/INS)
//  that freezes architectural writes once the machine stops.
// PARAMETERS
//  NREG    15   architectural registers, ids 0..14; id 15 (4'hF) = "no register"
//  RSP_ID  4    register id of %rsp, used by call/ret/pushq/popq
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-high reset
//  icode        in   4   instruction code from fetch
//  rA           in   4   register A id from fetch (4'hF if none)
//  rB           in   4   register B id from fetch (4'hF if none)
//  instr_valid  in   1   fetch decoded a legal icode/ifun
//  imem_error   in   1   fetch address out of range
//  dmem_error   in   1   memory stage address error for this instruction
//  cnd          in   1   condition result from execute (gates cmovXX)
//  valE         in   64  ALU result
//  valM         in   64  data-memory read value
//  valA         out  64  regfile[srcA], 0 when srcA==F
//  valB         out  64  regfile[srcB], 0 when srcB==F
//  srcA,srcB    out  4   selected read ids (debug/forwarding)
//  dstE,dstM    out  4   selected write ids
//  stat         out  3   1=AOK 2=HLT 3=ADR 4=INS
//  halted       out  1   1 when stat != AOK
// BEHAVIOUR
//  Reset: all 15 registers <= 0, stat <= AOK, halted <= 0; valA/valB follow reset-cleared regs.
//  Select logic (combinational, icode hex):
//   srcA = rA for 2,4,6,A; RSP_ID for 9,B; else F.
//   srcB = rB for 4,5,6;   RSP_ID for 8,9,A,B; else F.
//   dstE = rB for 3,6; rB for 2 only when cnd=1; RSP_ID for 8,9,A,B; else F.
//   dstM = rA for 5,B; else F.
//  Reads: zero latency, combinational from current register contents; a write at edge N is
//   visible on valA/valB after edge N (no internal bypass).
//  Writes: at posedge, when !reset and stat==AOK and new_stat==AOK:
//   dstE!=F -> reg[dstE] <= valE; dstM!=F -> reg[dstM] <= valM.
//   dstE==dstM (popq %rsp): valM wins, valE discarded. Writes to F never occur.
//  new_stat priority (per instruction): imem_error -> ADR; !instr_valid -> INS; dmem_error -> ADR;
//   icode==0 -> HLT; else AOK. Register at posedge when stat==AOK.
//  Faulting/halting instruction commits NO register writes.
//  stat is sticky: once != AOK it holds until reset; all writes suppressed; halted=1.
//  Reset asserted mid-program: overrides any write on that edge; regs cleared same edge.
//  rA/rB of 4'hF on an instruction needing them: treated as F (read 0, write dropped).
// TESTING
//  reset, then irmovq $0x10,%rbx (icode3,rB=3,valE=0x10) -> next cycle reg3=0x10, valB read via OPq=0x10.
//  cmovle rA=3,rB=1 with cnd=0 -> dstE=F, reg1 unchanged; repeat cnd=1 -> reg1=reg3.
//  popq %rsp: rA=4, valE=0x108, valM=0xABCD -> reg4=0xABCD after edge.
//  pushq %rax (icode A, rA=0): srcA=0, srcB=4, dstE=4, dstM=F; valE written to %rsp.
//  halt (icode0) -> stat=2, halted=1; following irmovq leaves regs unchanged; reset -> stat=1, regs=0.
//  mrmovq with dmem_error=1 -> stat=3, dstM reg not written; instr_valid=0 -> stat=4.

Source files
------------

// File: rtl/decode_writeback.sv
`default_nettype none
// ============================================================================
// Module   : decode_writeback
// Brief    : SEQ decode/write-back stage: register selection, 15x64 register
//            file with combinational reads, and sticky processor status.
// Revision : 1.0 - initial release
// ============================================================================
module decode_writeback #(
   parameter int NREG   = 15,
   parameter int RSP_ID = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        instr_valid,
   input  logic        imem_error,
   input  logic        dmem_error,
   input  logic        cnd,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [3:0]  dstM,
   output logic [2:0]  stat,
   output logic        halted
);

   localparam logic [3:0] c_rnone = 4'hF;
   localparam logic [3:0] c_rsp   = 4'(RSP_ID);
   localparam logic [2:0] c_aok   = 3'd1;
   localparam logic [2:0] c_hlt   = 3'd2;
   localparam logic [2:0] c_adr   = 3'd3;
   localparam logic [2:0] c_ins   = 3'd4;

   logic [63:0] r_regs [0:NREG-1];
   logic [2:0]  r_stat;
   logic [2:0]  w_new_stat;
   logic [3:0]  w_src_a, w_src_b, w_dst_e, w_dst_m;

   always_comb begin
      w_src_a = c_rnone;
      w_src_b = c_rnone;
      w_dst_e = c_rnone;
      w_dst_m = c_rnone;
      case (icode)
         4'h2, 4'h4, 4'h6, 4'hA: w_src_a = rA;
         4'h9, 4'hB:             w_src_a = c_rsp;
         default: ;
      endcase
      case (icode)
         4'h4, 4'h5, 4'h6:         w_src_b = rB;
         4'h8, 4'h9, 4'hA, 4'hB:   w_src_b = c_rsp;
         default: ;
      endcase
      case (icode)
         4'h3, 4'h6:               w_dst_e = rB;
         4'h2:                     w_dst_e = cnd ? rB : c_rnone;
         4'h8, 4'h9, 4'hA, 4'hB:   w_dst_e = c_rsp;
         default: ;
      endcase
      case (icode)
         4'h5, 4'hB: w_dst_m = rA;
         default: ;
      endcase
   end

   always_comb begin
      if (imem_error)        w_new_stat = c_adr;
      else if (!instr_valid) w_new_stat = c_ins;
      else if (dmem_error)   w_new_stat = c_adr;
      else if (icode == 4'h0) w_new_stat = c_hlt;
      else                   w_new_stat = c_aok;
   end

   // Ids at or above NREG (including 4'hF) read as zero.
   assign valA = (w_src_a < 4'(NREG)) ? r_regs[w_src_a] : 64'd0;
   assign valB = (w_src_b < 4'(NREG)) ? r_regs[w_src_b] : 64'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= 64'd0;
         r_stat <= c_aok;
      end else if (r_stat == c_aok) begin
         r_stat <= w_new_stat;
         if (w_new_stat == c_aok) begin
            if (w_dst_e < 4'(NREG)) r_regs[w_dst_e] <= valE;
            // Second assignment wins so popq %rsp keeps the memory value.
            if (w_dst_m < 4'(NREG)) r_regs[w_dst_m] <= valM;
         end
      end
   end

   assign srcA   = w_src_a;
   assign srcB   = w_src_b;
   assign dstE   = w_dst_e;
   assign dstM   = w_dst_m;
   assign stat   = r_stat;
   assign halted = (r_stat != c_aok);

endmodule
`default_nettype wire

// File: tb/tb_decode_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_writeback
// Brief    : Directed self-checking bench for decode_writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_writeback;

   logic        clk = 1'b0;
   logic        reset, instr_valid, imem_error, dmem_error, cnd;
   logic [3:0]  icode, rA, rB;
   logic [63:0] valE, valM;
   logic [63:0] valA, valB;
   logic [3:0]  srcA, srcB, dstE, dstM;
   logic [2:0]  stat;
   logic        halted;

   int total = 0;
   int bad   = 0;

   decode_writeback #(.NREG(15), .RSP_ID(4)) dut (
      .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB),
      .instr_valid(instr_valid), .imem_error(imem_error),
      .dmem_error(dmem_error), .cnd(cnd), .valE(valE), .valM(valM),
      .valA(valA), .valB(valB), .srcA(srcA), .srcB(srcB),
      .dstE(dstE), .dstM(dstM), .stat(stat), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic [63:0] e, input logic [63:0] m);
      icode = ic; rA = a; rB = b; valE = e; valM = m;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // OPq addresses both read ports with no clock edge, so nothing is written.
   task automatic peek(input logic [3:0] a, input logic [3:0] b);
      drive(4'h6, a, b, 64'd0, 64'd0);
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0; cnd = 1'b0;
      drive(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_stat", 64'(stat), 64'd1);
      chk("rst_halted", 64'(halted), 64'd0);
      peek(4'd3, 4'd7);
      chk("rst_valA", valA, 64'd0);
      chk("rst_valB", valB, 64'd0);

      // irmovq $0x10,%rbx
      drive(4'h3, 4'hF, 4'd3, 64'h10, 64'd0);
      chk("irm_srcA", 64'(srcA), 64'hF);
      chk("irm_srcB", 64'(srcB), 64'hF);
      chk("irm_dstE", 64'(dstE), 64'd3);
      chk("irm_dstM", 64'(dstM), 64'hF);
      chk("irm_valA_none", valA, 64'd0);
      tick();
      peek(4'd3, 4'd3);
      chk("irm_valA", valA, 64'h10);
      chk("irm_valB", valB, 64'h10);

      // cmovle %rbx,%rcx not taken
      cnd = 1'b0;
      drive(4'h2, 4'd3, 4'd1, 64'h10, 64'd0);
      chk("cmov0_dstE", 64'(dstE), 64'hF);
      chk("cmov0_srcA", 64'(srcA), 64'd3);
      chk("cmov0_valA", valA, 64'h10);
      tick();
      peek(4'd1, 4'hF);
      chk("cmov0_reg1", valA, 64'd0);
      chk("opq_rbF_valB", valB, 64'd0);
      // taken
      cnd = 1'b1;
      drive(4'h2, 4'd3, 4'd1, 64'h10, 64'd0);
      chk("cmov1_dstE", 64'(dstE), 64'd1);
      tick();
      cnd = 1'b0;
      peek(4'd1, 4'hF);
      chk("cmov1_reg1", valA, 64'h10);

      // popq %rsp: valM beats valE
      drive(4'hB, 4'd4, 4'hF, 64'h108, 64'hABCD);
      chk("pop_srcA", 64'(srcA), 64'd4);
      chk("pop_srcB", 64'(srcB), 64'd4);
      chk("pop_dstE", 64'(dstE), 64'd4);
      chk("pop_dstM", 64'(dstM), 64'd4);
      tick();
      peek(4'd4, 4'hF);
      chk("pop_reg4", valA, 64'hABCD);

      // pushq %rax
      drive(4'hA, 4'd0, 4'hF, 64'hABC5, 64'd0);
      chk("push_srcA", 64'(srcA), 64'd0);
      chk("push_srcB", 64'(srcB), 64'd4);
      chk("push_dstE", 64'(dstE), 64'd4);
      chk("push_dstM", 64'(dstM), 64'hF);
      chk("push_valB", valB, 64'hABCD);
      tick();
      peek(4'd4, 4'd0);
      chk("push_reg4", valA, 64'hABC5);
      chk("push_reg0", valB, 64'd0);

      // halt, then writes frozen
      drive(4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
      tick();
      chk("hlt_stat", 64'(stat), 64'd2);
      chk("hlt_halted", 64'(halted), 64'd1);
      drive(4'h3, 4'hF, 4'd5, 64'h77, 64'd0);
      tick();
      chk("hlt_sticky", 64'(stat), 64'd2);
      peek(4'd5, 4'd3);
      chk("hlt_reg5", valA, 64'd0);
      chk("hlt_reg3", valB, 64'h10);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst2_stat", 64'(stat), 64'd1);
      chk("rst2_halted", 64'(halted), 64'd0);
      peek(4'd3, 4'd4);
      chk("rst2_reg3", valA, 64'd0);
      chk("rst2_reg4", valB, 64'd0);

      // mrmovq with dmem_error: ADR, no load committed
      dmem_error = 1'b1;
      drive(4'h5, 4'd2, 4'd4, 64'h20, 64'h55);
      chk("mrm_dstM", 64'(dstM), 64'd2);
      tick();
      dmem_error = 1'b0;
      chk("adr_stat", 64'(stat), 64'd3);
      chk("adr_halted", 64'(halted), 64'd1);
      peek(4'd2, 4'hF);
      chk("adr_reg2", valA, 64'd0);

      // reset on the same edge as a write: reset wins
      reset = 1'b1;
      drive(4'h3, 4'hF, 4'd6, 64'h99, 64'd0);
      tick();
      reset = 1'b0;
      peek(4'd6, 4'hF);
      chk("rstw_reg6", valA, 64'd0);
      chk("rstw_stat", 64'(stat), 64'd1);

      // illegal instruction
      instr_valid = 1'b0;
      drive(4'h3, 4'hF, 4'd7, 64'h42, 64'd0);
      tick();
      instr_valid = 1'b1;
      chk("ins_stat", 64'(stat), 64'd4);
      peek(4'd7, 4'hF);
      chk("ins_reg7", valA, 64'd0);

      // imem_error outranks !instr_valid
      reset = 1'b1;
      tick();
      reset = 1'b0;
      imem_error = 1'b1; instr_valid = 1'b0;
      drive(4'h3, 4'hF, 4'd7, 64'h42, 64'd0);
      tick();
      imem_error = 1'b0; instr_valid = 1'b1;
      chk("prio_stat", 64'(stat), 64'd3);

      // reg 14 boundary write/read after recovery
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(4'h3, 4'hF, 4'd14, 64'hDEAD_BEEF_0000_0001, 64'd0);
      tick();
      peek(4'd14, 4'd13);
      chk("r14_valA", valA, 64'hDEAD_BEEF_0000_0001);
      chk("r13_valB", valB, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
